// File: rtl/fifo_sdp_fwft_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fifo_sdp_fwft_ctrl_pkg
// Shared definitions for the SDP-RAM FWFT FIFO controller:
//   - depth / counter width helpers derived from the RAM address width
//   - output buffer depth (OB_DEPTH)
//   - output-buffer occupancy state encoding (EMPTY/ONE/TWO)
// No ports (package).
// ---------------------------------------------------------------------------
package fifo_sdp_fwft_ctrl_pkg;

    localparam int OB_DEPTH = 2;

    // The encoding equals the number of words held, so the state register
    // doubles as ob_cnt without a separate counter.
    typedef enum logic [1:0] {
        OB_EMPTY = 2'd0,
        OB_ONE   = 2'd1,
        OB_TWO   = 2'd2
    } ob_state_t;

    // DEPTH = 2**ADDR_WIDTH
    function automatic int calc_depth(input int addr_width);
        return 2 ** addr_width;
    endfunction

    // CNT_WIDTH = ADDR_WIDTH + 2, enough for DEPTH + OB_DEPTH words
    function automatic int calc_cnt_width(input int addr_width);
        return addr_width + 2;
    endfunction

endpackage

// File: rtl/fifo_sdp_fwft_ctrl_out_skid2.sv
// ---------------------------------------------------------------------------
// fifo_out_skid2
// Two-entry output buffer that turns the RAM's registered read into a
// first-word-fall-through stream. Words arrive on capture/cap_data and leave
// through the rd_valid/rd_ready handshake.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   capture      a RAM read word is on cap_data this cycle
//   cap_data     RAM read data
//   rd_ready     downstream accepts the head word
//   rd_valid     head word valid (buffer not empty)
//   rd_data      head word (registered)
//   pop          rd_valid & rd_ready
//   ob_cnt       words held (0..2)
// ---------------------------------------------------------------------------
module fifo_out_skid2
    import fifo_sdp_fwft_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  pop,
    output logic [1:0]            ob_cnt
);

    ob_state_t             state_q;
    ob_state_t             state_d;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] skid_q;

    assign rd_valid = (state_q != OB_EMPTY);
    assign pop      = rd_valid & rd_ready;
    assign rd_data  = head_q;
    assign ob_cnt   = state_q;

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OB_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture moves up one state, pop moves down one, both together hold.
    // The issue logic upstream never lets a capture land in TWO.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OB_EMPTY: if (capture)          state_d = OB_ONE;
            OB_ONE: begin
                if (capture && !pop)        state_d = OB_TWO;
                else if (pop && !capture)   state_d = OB_EMPTY;
            end
            OB_TWO:   if (pop && !capture)  state_d = OB_ONE;
            default:                        state_d = OB_EMPTY;
        endcase
    end

    // Data path: the head register feeds rd_data directly; the skid entry
    // only fills when a capture arrives while the head is still waiting.
    // On an empty buffer head_q keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            unique case (state_q)
                OB_EMPTY: if (capture) head_q <= cap_data;
                OB_ONE: begin
                    if (capture && pop)  head_q <= cap_data;
                    else if (capture)    skid_q <= cap_data;
                end
                OB_TWO:   if (pop)     head_q <= skid_q;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_sdp_fwft_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_sdp_fwft_ctrl
// Synchronous FIFO controller around an external simple-dual-port RAM
// (port A write, port B read with 1-cycle registered read). Presents a
// first-word-fall-through valid/ready stream using a 2-entry output buffer.
// Optional feature: define FIFO_ALMOST_FULL_EN to build the registered
// almost_full flag; otherwise almost_full is tied to 0.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_data      upstream write stream
//   rd_valid/rd_ready/rd_data      downstream FWFT read stream
//   fill_cnt                       words held (RAM + in flight + buffer)
//   almost_full                    fill_cnt >= ALMOST_FULL_THRESH
//   ram_ena/ram_wea/ram_addra/ram_dia   RAM port A (write)
//   ram_enb/ram_addrb/ram_dob           RAM port B (read)
// ---------------------------------------------------------------------------
module fifo_sdp_fwft_ctrl
    import fifo_sdp_fwft_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDR_WIDTH         = 5,
    parameter int ALMOST_FULL_THRESH = calc_depth(ADDR_WIDTH) - 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic [calc_cnt_width(ADDR_WIDTH)-1:0] fill_cnt,
    output logic                              almost_full,
    output logic                              ram_ena,
    output logic                              ram_wea,
    output logic [ADDR_WIDTH-1:0]             ram_addra,
    output logic [DATA_WIDTH-1:0]             ram_dia,
    output logic                              ram_enb,
    output logic [ADDR_WIDTH-1:0]             ram_addrb,
    input  logic [DATA_WIDTH-1:0]             ram_dob
);

    localparam int DEPTH     = calc_depth(ADDR_WIDTH);
    localparam int CNT_WIDTH = calc_cnt_width(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic                  inflight;
    logic [1:0]            ob_cnt;
    logic [2:0]            ob_next_occ;
    logic                  push;
    logic                  pop;
    logic                  issue;

    // Full is judged on RAM occupancy alone, so wr_ready is a pure register
    // decode and never depends on rd_ready.
    assign wr_ready = (ram_cnt != (ADDR_WIDTH+1)'(DEPTH));
    assign push     = wr_valid & wr_ready;

    // Issue a read only if the word it returns will have a buffer slot once
    // the current in-flight word lands and this cycle's pop leaves.
    assign ob_next_occ = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue       = (ram_cnt != '0) && (ob_next_occ < 3'd2);

    assign ram_ena   = push;
    assign ram_wea   = push;
    assign ram_addra = wr_ptr;
    assign ram_dia   = wr_data;
    assign ram_enb   = issue;
    assign ram_addrb = rd_ptr;

    assign fill_cnt = CNT_WIDTH'(ram_cnt) + CNT_WIDTH'(inflight) + CNT_WIDTH'(ob_cnt);

    // Pointers wrap naturally at DEPTH; ram_cnt carries the extra bit that
    // distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            if (push && !issue)      ram_cnt <= ram_cnt + 1'b1;
            else if (issue && !push) ram_cnt <= ram_cnt - 1'b1;
            inflight <= issue;
        end
    end

    fifo_out_skid2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_skid2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture  (inflight),
        .cap_data (ram_dob),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .pop      (pop),
        .ob_cnt   (ob_cnt)
    );

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [CNT_WIDTH-1:0] AF_THRESH = CNT_WIDTH'(ALMOST_FULL_THRESH);

    logic [CNT_WIDTH-1:0] fill_next;

    // Every word entering or leaving the FIFO does so through push or pop,
    // so next fill is simply fill_cnt + push - pop; registering the compare
    // keeps the flag in step with fill_cnt.
    assign fill_next = fill_cnt + CNT_WIDTH'(push) - CNT_WIDTH'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (fill_next >= AF_THRESH);
        end
    end
`else
    assign almost_full = 1'b0;
`endif

endmodule

// File: doc/fifo_sdp_fwft_ctrl.md
Name: fifo_sdp_fwft_ctrl

Overview:
- Synchronous FIFO controller that drives an external simple-dual-port RAM: port A write, port B read, 1-cycle registered read latency.
- Converts the RAM's registered read into a first-word-fall-through valid/ready stream, with a 2-entry output buffer that hides the read latency at full throughput.
- Sits directly around the RAM: it feeds the RAM's write/read ports and consumes the RAM's dob output.

Parameters:
- DATA_WIDTH, 8, width of the data word (equals the RAM data width).
- ADDR_WIDTH, 5, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH.
- ALMOST_FULL_THRESH, DEPTH-2, fill_cnt level at or above which almost_full asserts (used only with the optional feature).

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  upstream word valid.
- wr_ready  out  1  FIFO can accept a word.
- wr_data  in  DATA_WIDTH  upstream word.
- rd_valid  out  1  head word valid.
- rd_ready  in  1  downstream accepts the head word.
- rd_data  out  DATA_WIDTH  head word.
- fill_cnt  out  ADDR_WIDTH+2  total words held (RAM + in-flight + output buffer).
- almost_full  out  1  fill_cnt >= ALMOST_FULL_THRESH (optional feature; otherwise 0).
- ram_ena  out  1  RAM port A enable.
- ram_wea  out  1  RAM port A write enable.
- ram_addra  out  ADDR_WIDTH  RAM write address.
- ram_dia  out  DATA_WIDTH  RAM write data.
- ram_enb  out  1  RAM port B read enable.
- ram_addrb  out  ADDR_WIDTH  RAM read address.
- ram_dob  in  DATA_WIDTH  RAM read data, valid the cycle after ram_enb.

Behaviour:
- Reset (async assert, rst_n low):
  - wr_ptr, rd_ptr, ram_cnt, inflight and ob_cnt all go to 0.
  - Outputs: rd_valid=0, wr_ready=1 after reset, fill_cnt=0, almost_full=0, ram_enb=0.
  - RAM contents are not cleared; stale words are unreachable.
  - Reset mid-operation discards all data, including any in-flight read.
- Push:
  - push = wr_valid & wr_ready.
  - ram_ena = ram_wea = push; ram_addra = wr_ptr; ram_dia = wr_data.
  - wr_ptr increments on push and wraps naturally at DEPTH.
  - wr_ready = (ram_cnt != DEPTH), derived from registers only; it never depends on rd_ready.
- Read issue:
  - issue = (ram_cnt != 0) & ((ob_cnt + inflight - pop) < 2).
  - ram_enb = issue; ram_addrb = rd_ptr; rd_ptr increments and wraps on issue.
  - inflight <= issue.
  - A word pushed in cycle t is readable from t+1, because ram_cnt updates at the end of t.
- Capture: when inflight=1, ram_dob is written into the output buffer tail at the end of that cycle.
- Pop and output buffer:
  - pop = rd_valid & rd_ready; rd_valid = (ob_cnt != 0); rd_data = buffer head (registered).
  - A simultaneous pop and capture keeps ob_cnt unchanged; the skid entry shifts to head when one exists.
- Counts:
  - ram_cnt += push - issue; simultaneous push and issue leave it unchanged.
  - fill_cnt = ram_cnt + inflight + ob_cnt; maximum DEPTH+2.
- Latency: a push into an empty FIFO in cycle t gives rd_valid in cycle t+3.
- Throughput: sustained 1 word/cycle in and out.
- Full: ram_cnt == DEPTH drops wr_ready. Pushes while wr_ready=0 are ignored and no RAM write occurs.
- Empty: rd_valid=0, and rd_data holds its last value. A pop while rd_valid=0 has no effect.
- Ordering: strict FIFO across pointer wrap-around.
- Internal state machine (per output-buffer state):
  - EMPTY: ob_cnt=0.
  - ONE: ob_cnt=1.
  - TWO: ob_cnt=2.
  - Transitions follow capture/pop: capture only goes +1, pop only goes -1, both together hold. Capture in TWO is impossible by construction.

Optional Feature:
- Macro FIFO_ALMOST_FULL_EN.
- Defined: register almost_full <= (next fill_cnt >= ALMOST_FULL_THRESH); it updates in the same cycle as fill_cnt.
- Undefined: almost_full is tied to 0, the comparator and register are not built, and ALMOST_FULL_THRESH is ignored.

Decomposition:
- Shared package/header holds:
  - DEPTH = 2**ADDR_WIDTH.
  - OB_DEPTH = 2.
  - CNT_WIDTH = ADDR_WIDTH+2.
  - The output-buffer state encoding (EMPTY/ONE/TWO).
- Natural sub-module: fifo_out_skid2, the 2-entry output buffer with capture/pop, ob_cnt, rd_valid and rd_data.
- Pointers, counters and RAM port drive stay in the top level.

Test Plan:
- Reset, then push 0xA5 at cycle t with rd_ready=1 -> ram_enb in t+1, rd_valid/rd_data=0xA5 in t+3, fill_cnt back to 0 after the pop.
- Continuous push of 0..63 with rd_ready=1 (ADDR_WIDTH=5) -> output 0..63 in order at 1 word/cycle after the 3-cycle fill, with pointer wrap exercised.
- rd_ready=0, push until wr_ready=0 -> exactly 34 words accepted (32 RAM + 2 buffer), fill_cnt=34, no RAM write while full.
- From full, toggle rd_ready with 50% random stalls while pushing -> no loss or duplication, order preserved, fill_cnt consistent every cycle.
- Assert rst_n low mid-stream with one read in flight -> rd_valid=0 and fill_cnt=0 immediately; data pushed after reset is output first, and stale data never appears.
- FIFO_ALMOST_FULL_EN defined, ALMOST_FULL_THRESH=30 -> almost_full rises when fill_cnt reaches 30 and falls at 29; with the macro undefined it stays 0.
